// File: rtl/z16_sequencer.sv
// Multi-cycle control sequencer for the z16 core: fetch, decode, execute, memory, writeback.
// One state register. Every strobe is decoded combinationally from the state and the current inputs.
module z16_sequencer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_halt,
  input  logic [3:0]  i_opcode,
  input  logic        i_branch_taken,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_ir_wen,
  output logic        o_rf_wen,
  output logic        o_pc_wen,
  output logic [1:0]  o_pc_sel,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_state,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_retire_cnt
);

  // Handshake: a request stays high until the cycle its ack is seen. That
  // ack cycle completes the transfer. Acks that arrive in any other state
  // have no effect.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          halt_q;
  logic          halt_go;
  logic          retire;
  logic          timeout;
  logic          is_branch;
  logic          is_mem;
  logic          is_store;

  assign is_branch = (i_opcode == 4'hE) || (i_opcode == 4'hF);
  assign is_mem    = (i_opcode == 4'hA) || (i_opcode == 4'hB);
  assign is_store  = (i_opcode == 4'hB);
  // This is the last allowed wait cycle. An ack in this same cycle still wins.
  assign timeout   = (wait_cnt == WW'(ACK_TIMEOUT - 1));
  assign halt_go   = halt_q | i_halt;

  assign o_state = state;
  assign o_busy  = (state != S_IDLE) && (state != S_ERR);
  assign o_err   = (state == S_ERR);

  always_comb begin
    state_nxt  = state;
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_ir_wen   = 1'b0;
    o_rf_wen   = 1'b0;
    o_pc_wen   = 1'b0;
    o_pc_sel   = 2'd0;
    o_wb_sel   = 2'd0;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_wen  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_branch) begin
          o_pc_wen = 1'b1;
          o_pc_sel = i_branch_taken ? 2'd1 : 2'd0;
          retire   = 1'b1;
        end else if (is_mem) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_store;
        if (i_dmem_ack) begin
          if (is_store) begin
            o_pc_wen = 1'b1;
            retire   = 1'b1;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        o_rf_wen = 1'b1;
        o_pc_wen = 1'b1;
        retire   = 1'b1;
        if (i_opcode == 4'hA) o_wb_sel = 2'd1;
        else if ((i_opcode == 4'hC) || (i_opcode == 4'hD)) o_wb_sel = 2'd2;
        if (i_opcode == 4'hC) o_pc_sel = 2'd1;
        else if (i_opcode == 4'hD) o_pc_sel = 2'd2;
      end
      S_ERR: state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (retire) state_nxt = halt_go ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      halt_q       <= 1'b0;
      o_retire_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      // The counter only runs while a request stays in the same waiting state. Any exit clears it.
      if (((state == S_FETCH) || (state == S_MEM)) && (state_nxt == state))
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;
      if (retire)
        halt_q <= 1'b0;
      else if (i_halt && o_busy)
        halt_q <= 1'b1;
      if (retire) o_retire_cnt <= o_retire_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_z16_sequencer.sv
// Bench for z16_sequencer. An instruction-level model expands each instruction into per-cycle stimulus and expected outputs.
// A single driver loop replays both queues in lockstep.
module tb_z16_sequencer;

  localparam int EW = 31;

  typedef struct packed {
    logic [2:0]  state;
    logic        busy, err, imem_req, dmem_req, dmem_we, ir_wen, rf_wen, pc_wen;
    logic [1:0]  pc_sel, wb_sel;
    logic [15:0] retire;
  } exp_t;

  typedef struct packed {
    logic       rst, start, halt, imem_ack, dmem_ack, taken;
    logic [3:0] opcode;
  } drv_t;

  logic        clk = 1'b0;
  logic        rst, start, halt, branch_taken, imem_ack, dmem_ack;
  logic [3:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_wen, rf_wen, pc_wen, busy, err;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [15:0] retire_cnt;

  always #5 clk = ~clk;

  z16_sequencer #(.ACK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt),
    .i_opcode(opcode), .i_branch_taken(branch_taken),
    .o_imem_req(imem_req), .i_imem_ack(imem_ack),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
    .o_ir_wen(ir_wen), .o_rf_wen(rf_wen), .o_pc_wen(pc_wen),
    .o_pc_sel(pc_sel), .o_wb_sel(wb_sel), .o_state(state),
    .o_busy(busy), .o_err(err), .o_retire_cnt(retire_cnt)
  );

  logic [EW-1:0] exp_q[$];
  drv_t          drv_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [15:0]   m_retire;
  logic          m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for one cycle in state st, before any strobes are added.
  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e        = '0;
    e.state  = st;
    e.busy   = (st != 3'd0) && (st != 3'd7);
    e.err    = (st == 3'd7);
    e.retire = m_retire;
    return e;
  endfunction

  // Random inputs for a cycle. Acks are stray unless the caller overrides them. A halt fires when k == halt_at.
  function automatic drv_t mk_drv(input logic [3:0] op, input int k, input int halt_at);
    drv_t d;
    d          = '0;
    d.opcode   = op;
    d.start    = 1'($urandom_range(0, 1));
    d.taken    = 1'($urandom_range(0, 1));
    d.imem_ack = 1'($urandom_range(0, 1));
    d.dmem_ack = 1'($urandom_range(0, 1));
    d.halt     = (k == halt_at);
    if (d.halt) m_halt = 1'b1;
    return d;
  endfunction

  task automatic push(input drv_t d, input exp_t e);
    drv_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic retire_step(output bit halted);
    m_retire = m_retire + 16'd1;
    halted   = m_halt;
    m_halt   = 1'b0;
  endtask

  task automatic gen_idle(input int n);
    drv_t d;
    for (int i = 0; i < n; i++) begin
      d       = mk_drv(4'($urandom_range(0, 15)), 0, -1);
      d.start = 1'b0;
      d.halt  = 1'($urandom_range(0, 1));
      push(d, base(3'd0));
    end
  endtask

  task automatic gen_start();
    drv_t d;
    d       = mk_drv(4'($urandom_range(0, 15)), 0, -1);
    d.start = 1'b1;
    push(d, base(3'd0));
  endtask

  task automatic gen_instr(input logic [3:0] op, input int iw, input int dw,
                           input int halt_at, output bit halted);
    drv_t d;
    exp_t e;
    int   k;
    bit   br, mem, st;
    br = (op >= 4'hE);
    mem = (op == 4'hA) || (op == 4'hB);
    st = (op == 4'hB);
    k = 0;
    halted = 1'b0;
    for (int i = 0; i <= iw; i++) begin
      d = mk_drv(op, k, halt_at); d.imem_ack = (i == iw);
      e = base(3'd1); e.imem_req = 1'b1; e.ir_wen = (i == iw);
      push(d, e); k++;
    end
    d = mk_drv(op, k, halt_at); push(d, base(3'd2)); k++;
    d = mk_drv(op, k, halt_at); e = base(3'd3);
    if (br) begin
      e.pc_wen = 1'b1;
      e.pc_sel = d.taken ? 2'd1 : 2'd0;
      push(d, e);
      retire_step(halted);
      return;
    end
    push(d, e); k++;
    if (mem) begin
      for (int i = 0; i <= dw; i++) begin
        d = mk_drv(op, k, halt_at); d.dmem_ack = (i == dw);
        e = base(3'd4); e.dmem_req = 1'b1; e.dmem_we = st;
        if (st && (i == dw)) e.pc_wen = 1'b1;
        push(d, e); k++;
      end
      if (st) begin
        retire_step(halted);
        return;
      end
    end
    d = mk_drv(op, k, halt_at); e = base(3'd5);
    e.rf_wen = 1'b1; e.pc_wen = 1'b1;
    e.wb_sel = (op == 4'hA) ? 2'd1 : ((op == 4'hC) || (op == 4'hD)) ? 2'd2 : 2'd0;
    e.pc_sel = (op == 4'hC) ? 2'd1 : (op == 4'hD) ? 2'd2 : 2'd0;
    push(d, e);
    retire_step(halted);
  endtask

  task automatic do_instr(input logic [3:0] op, input int iw, input int dw, input int halt_at);
    bit h;
    gen_instr(op, iw, dw, halt_at, h);
    if (h) begin
      gen_idle($urandom_range(1, 3));
      gen_start();
    end
  endtask

  // 16 cycles of waiting with no ack, then the error state. Only reset leaves it.
  task automatic gen_timeout(input bit in_mem);
    drv_t d;
    exp_t e;
    if (in_mem) begin
      d = mk_drv(4'hA, 0, -1); d.imem_ack = 1'b1;
      e = base(3'd1); e.imem_req = 1'b1; e.ir_wen = 1'b1; push(d, e);
      push(mk_drv(4'hA, 0, -1), base(3'd2));
      push(mk_drv(4'hA, 0, -1), base(3'd3));
    end
    for (int i = 0; i < 16; i++) begin
      d = mk_drv(4'hA, 0, -1);
      if (in_mem) begin
        d.dmem_ack = 1'b0; e = base(3'd4); e.dmem_req = 1'b1;
      end else begin
        d.imem_ack = 1'b0; e = base(3'd1); e.imem_req = 1'b1;
      end
      push(d, e);
    end
    for (int i = 0; i < 4; i++) begin
      d = mk_drv(4'hA, 0, -1); d.start = 1'b1; d.halt = 1'($urandom_range(0, 1));
      push(d, base(3'd7));
    end
    d = mk_drv(4'hA, 0, -1); d.rst = 1'b1; d.start = 1'b1;
    push(d, base(3'd7));
    m_retire = 16'd0;
    m_halt   = 1'b0;
  endtask

  // Load interrupted by reset during its memory wait. The halt pulsed in DECODE must not survive the reset.
  task automatic gen_reset_mid_mem();
    drv_t d;
    exp_t e;
    d = mk_drv(4'hA, 0, -1); d.imem_ack = 1'b1;
    e = base(3'd1); e.imem_req = 1'b1; e.ir_wen = 1'b1; push(d, e);
    d = mk_drv(4'hA, 0, 0); push(d, base(3'd2));
    push(mk_drv(4'hA, 0, -1), base(3'd3));
    for (int i = 0; i < 2; i++) begin
      d = mk_drv(4'hA, 0, -1); d.dmem_ack = 1'b0;
      e = base(3'd4); e.dmem_req = 1'b1; push(d, e);
    end
    d = mk_drv(4'hA, 0, -1); d.rst = 1'b1; d.dmem_ack = 1'b1; d.start = 1'b1;
    e = base(3'd4); e.dmem_req = 1'b1; push(d, e);
    m_retire = 16'd0;
    m_halt   = 1'b0;
  endtask

  task automatic run_queue();
    drv_t d;
    exp_t e;
    while (drv_q.size() > 0) begin
      d = drv_q.pop_front();
      e = exp_q.pop_front();
      rst = d.rst; start = d.start; halt = d.halt; opcode = d.opcode;
      branch_taken = d.taken; imem_ack = d.imem_ack; dmem_ack = d.dmem_ack;
      #1;
      check("state", 32'(state), 32'(e.state));
      check("ctrl", 32'({busy, err, imem_req, dmem_req, dmem_we, ir_wen, rf_wen, pc_wen, pc_sel, wb_sel}),
            32'({e.busy, e.err, e.imem_req, e.dmem_req, e.dmem_we, e.ir_wen, e.rf_wen, e.pc_wen,
                 e.pc_sel, e.wb_sel}));
      check("retire_cnt", 32'(retire_cnt), 32'(e.retire));
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; opcode = 4'h0;
    branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    m_retire = 16'd0; m_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    gen_idle(2);
    gen_start();
    do_instr(4'h1, 0, 0, -1);
    do_instr(4'hA, 0, 3, -1);
    do_instr(4'hB, 0, 3, -1);
    do_instr(4'hE, 0, 0, -1);
    do_instr(4'hF, 1, 0, -1);
    do_instr(4'hD, 0, 0, -1);
    do_instr(4'hC, 2, 0, -1);
    do_instr(4'h1, 0, 0, 1);
    do_instr(4'h3, 15, 0, -1);
    do_instr(4'hA, 0, 15, -1);
    gen_reset_mid_mem();
    gen_idle(2);
    gen_start();
    do_instr(4'h5, 0, 0, -1);
    do_instr(4'hB, 1, 0, -1);
    gen_timeout(1'b0);
    gen_idle(2);
    gen_start();
    gen_timeout(1'b1);
    gen_idle(2);
    gen_start();
    for (int n = 0; n < 200; n++) begin
      do_instr(4'($urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1);
    end
    run_queue();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
